// File: rtl/btn_ctrl_pkg.sv
// Shared types for the button event controller: debounce FSM states and
// event_type codes.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } btn_state_e;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_RSVD    = 2'b11;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Optional LONG_PRESS_EN adds a saturating hold counter in STABLE_HI.
module btn_channel
  import btn_ctrl_pkg::*;
#(
  parameter int N_MAX = 50
`ifdef LONG_PRESS_EN
  , parameter int LONG_MAX = 50000
`endif
) (
  input  logic i_clk,
  input  logic i_rst_a_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press_set,
  output logic o_rel_set
`ifdef LONG_PRESS_EN
  , output logic o_long_set
`endif
);

  // N_MAX >= 2: the entry sample is the first of the N_MAX matching samples,
  // so acceptance happens while the counter holds N_MAX-2.
  localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MAX - 2);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  assign o_level     = r_level;
  assign o_press_set = (r_state == CHK_HI) && r_sync2 && (r_cnt == CNT_LAST);
  assign o_rel_set   = (r_state == CHK_LO) && !r_sync2 && (r_cnt == CNT_LAST);

  // Two-flop synchronizer for the raw button level
  always_ff @(posedge i_clk or negedge i_rst_a_n) begin
    if (!i_rst_a_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with qualification counter and registered level
  always_ff @(posedge i_clk or negedge i_rst_a_n) begin
    if (!i_rst_a_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        STABLE_LO: begin
          if (r_sync2) begin
            r_state <= CHK_HI;
            r_cnt   <= '0;
          end else begin
            r_state <= STABLE_LO;
          end
        end
        CHK_HI: begin
          if (!r_sync2) begin
            r_state <= STABLE_LO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HI;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!r_sync2) begin
            r_state <= CHK_LO;
            r_cnt   <= '0;
          end else begin
            r_state <= STABLE_HI;
          end
        end
        CHK_LO: begin
          if (r_sync2) begin
            r_state <= STABLE_HI;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  // LONG_MAX >= 2; the long strobe fires as the counter reaches LONG_MAX-1.
  localparam int HOLD_W = (LONG_MAX > 1) ? $clog2(LONG_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              w_holding;

  assign w_holding  = (r_state == STABLE_HI) && r_sync2;
  assign o_long_set = w_holding && (r_hold == HOLD_LAST - HOLD_W'(1));

  // Hold counter: runs while stably pressed, saturates, clears on leaving
  always_ff @(posedge i_clk or negedge i_rst_a_n) begin
    if (!i_rst_a_n) begin
      r_hold <= '0;
    end else if (!w_holding) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_LAST) begin
      r_hold <= r_hold + HOLD_W'(1);
    end else begin
      r_hold <= r_hold;
    end
  end
`endif

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounced multi-button event controller: per-channel pending bits and a
// round-robin event presenter. Optional macro: LONG_PRESS_EN (long-press events).
module btn_event_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int N_MAX    = 50,
  parameter int LONG_MAX = 50000
) (
  input  logic                                     clk,
  input  logic                                     rst_a_n,
  input  logic [N_BTN-1:0]                         btn_in,
  output logic [N_BTN-1:0]                         btn_level,
  output logic                                     event_valid,
  input  logic                                     event_ready,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] event_id,
  output logic [1:0]                               event_type,
  output logic                                     overflow
);

  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press_set;
  logic [N_BTN-1:0] w_rel_set;
  logic [N_BTN-1:0] w_long_pend;
  logic [N_BTN-1:0] w_press_clr;
  logic [N_BTN-1:0] w_rel_clr;
  logic [N_BTN-1:0] w_served_oh;
  logic             w_hs;
  logic             w_ovf;
  logic             w_long_ovf;

  logic [N_BTN-1:0] r_press_pend;
  logic [N_BTN-1:0] r_rel_pend;
  logic             r_event_valid;
  logic [ID_W-1:0]  r_event_id;
  logic [1:0]       r_event_type;
  logic             r_overflow;
  logic [ID_W-1:0]  r_rr_ptr;

  logic             w_sel_found;
  logic [ID_W-1:0]  w_sel_id;
  logic [1:0]       w_sel_type;
  logic [ID_W-1:0]  w_cand;

`ifdef LONG_PRESS_EN
  logic [N_BTN-1:0] w_long_set;
  logic [N_BTN-1:0] w_long_clr;
  logic [N_BTN-1:0] r_long_pend;
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .N_MAX(N_MAX)
`ifdef LONG_PRESS_EN
      , .LONG_MAX(LONG_MAX)
`endif
    ) u_ch (
      .i_clk      (clk),
      .i_rst_a_n  (rst_a_n),
      .i_btn      (btn_in[g]),
      .o_level    (w_level[g]),
      .o_press_set(w_press_set[g]),
      .o_rel_set  (w_rel_set[g])
`ifdef LONG_PRESS_EN
      , .o_long_set(w_long_set[g])
`endif
    );
  end

  assign btn_level   = w_level;
  assign event_valid = r_event_valid;
  assign event_id    = r_event_id;
  assign event_type  = r_event_type;
  assign overflow    = r_overflow;

  assign w_hs        = r_event_valid && event_ready;
  assign w_served_oh = N_BTN'(1) << r_event_id;
  assign w_press_clr = (w_hs && (r_event_type == EV_PRESS))   ? w_served_oh : '0;
  assign w_rel_clr   = (w_hs && (r_event_type == EV_RELEASE)) ? w_served_oh : '0;

  // A set that lands on an already-pending bit not served this cycle is lost
  assign w_ovf = (|(w_press_set & r_press_pend & ~w_press_clr)) ||
                 (|(w_rel_set & r_rel_pend & ~w_rel_clr)) || w_long_ovf;

`ifdef LONG_PRESS_EN
  assign w_long_clr  = (w_hs && (r_event_type == EV_LONG)) ? w_served_oh : '0;
  assign w_long_pend = r_long_pend;
  assign w_long_ovf  = |(w_long_set & r_long_pend & ~w_long_clr);

  // Long-press pending bits, set wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_long_pend <= '0;
    end else begin
      r_long_pend <= (r_long_pend & ~w_long_clr) | w_long_set;
    end
  end
`else
  logic w_unused_long;
  assign w_unused_long = (LONG_MAX > 0);
  assign w_long_pend   = '0;
  assign w_long_ovf    = 1'b0;
`endif

  // Press/release pending bits and sticky overflow
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_press_pend <= '0;
      r_rel_pend   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_press_pend <= (r_press_pend & ~w_press_clr) | w_press_set;
      r_rel_pend   <= (r_rel_pend & ~w_rel_clr) | w_rel_set;
      r_overflow   <= r_overflow | w_ovf;
    end
  end

  // Round-robin pick starting at r_rr_ptr; press > release > long per channel
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = '0;
    w_sel_type  = EV_PRESS;
    w_cand      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      w_cand = ((int'(r_rr_ptr) + k) >= N_BTN) ? ID_W'(int'(r_rr_ptr) + k - N_BTN)
                                                : ID_W'(int'(r_rr_ptr) + k);
      if (!w_sel_found && (r_press_pend[w_cand] || r_rel_pend[w_cand] || w_long_pend[w_cand])) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_cand;
        if (r_press_pend[w_cand]) begin
          w_sel_type = EV_PRESS;
        end else if (r_rel_pend[w_cand]) begin
          w_sel_type = EV_RELEASE;
        end else begin
          w_sel_type = EV_LONG;
        end
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Event presenter: holds the event until handshake, idles one cycle after
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_event_valid <= 1'b0;
      r_event_id    <= '0;
      r_event_type  <= EV_PRESS;
      r_rr_ptr      <= '0;
    end else if (r_event_valid) begin
      r_event_valid <= !event_ready;
    end else if (w_sel_found) begin
      r_event_valid <= 1'b1;
      r_event_id    <= w_sel_id;
      r_event_type  <= w_sel_type;
      r_rr_ptr      <= (w_sel_id == ID_W'(N_BTN - 1)) ? '0 : (w_sel_id + ID_W'(1));
    end else begin
      r_event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl (N_BTN=4, N_MAX=50, LONG_MAX=200, 20 ns clk).
// Honours LONG_PRESS_EN when the same macro is defined for the build.
module tb_btn_event_ctrl;

  localparam int N_BTN    = 4;
  localparam int N_MAX    = 50;
  localparam int LONG_MAX = 200;
  localparam int T_CLK    = 20;

  logic       clk = 1'b0;
  logic       rst_a_n;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_id;
  logic [1:0] event_type;
  logic       overflow;

  int n_total;
  int n_bad;

  typedef struct {
    int     id;
    int     typ;
    longint t;
  } ev_t;
  ev_t ev_q[$];
  bit  saw_long = 1'b0;

  typedef struct {
    int ch;
    int len;
    int exp_press;
    int exp_rel;
  } vec_t;
  vec_t vecs[5];

  int     exp_ids[7];
  int     exp_typ[7];
  longint t_edge;

  btn_event_ctrl #(
    .N_BTN(N_BTN),
    .N_MAX(N_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .clk        (clk),
    .rst_a_n    (rst_a_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_id   (event_id),
    .event_type (event_type),
    .overflow   (overflow)
  );

  always #(T_CLK / 2) clk = ~clk;

  // Record every accepted event with its handshake time
  always @(posedge clk) begin
    if (rst_a_n && event_valid && event_ready)
      ev_q.push_back('{int'(event_id), int'(event_type), longint'($time)});
    if (event_valid && (event_type == 2'b10))
      saw_long <= 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ev_id(input int i);
    return (i < ev_q.size()) ? ev_q[i].id : -1;
  endfunction

  function automatic int ev_typ(input int i);
    return (i < ev_q.size()) ? ev_q[i].typ : -1;
  endfunction

  function automatic int count_ev(input int id, input int typ);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].id == id && ev_q[i].typ == typ) n++;
    return n;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_a_n     = 1'b0;
    btn_in      = '0;
    event_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    ev_q.delete();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_a_n     = 1'b0;
    btn_in      = '0;
    event_ready = 1'b0;

    vecs[0] = '{2, 40, 0, 0};
    vecs[1] = '{1, 49, 0, 0};
    vecs[2] = '{3, 50, 1, 1};
    vecs[3] = '{0,  1, 0, 0};
    vecs[4] = '{2, 80, 1, 1};

    // reset state
    #35;
    check("rst_level", int'(btn_level), 0);
    check("rst_valid", int'(event_valid), 0);
    check("rst_id", int'(event_id), 0);
    check("rst_type", int'(event_type), 0);
    check("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst_a_n = 1'b1;

    // pulse-length table: pulses shorter than N_MAX samples are filtered
    for (int i = 0; i < 5; i++) begin
      apply_reset();
      event_ready = 1'b1;
      btn_in[vecs[i].ch] = 1'b1;
      repeat (vecs[i].len) @(negedge clk);
      btn_in[vecs[i].ch] = 1'b0;
      repeat (150) @(negedge clk);
      check($sformatf("vec%0d_press", i), count_ev(vecs[i].ch, 0), vecs[i].exp_press);
      check($sformatf("vec%0d_rel", i), count_ev(vecs[i].ch, 1), vecs[i].exp_rel);
      check($sformatf("vec%0d_events", i), ev_q.size(), vecs[i].exp_press + vecs[i].exp_rel);
      check($sformatf("vec%0d_level", i), int'(btn_level), 0);
    end

    // bouncing edge on channel 0, then clean hold
    apply_reset();
    event_ready = 1'b1;
    @(posedge clk);
    #1 btn_in[0] = 1'b1;
    #30 btn_in[0] = 1'b0;
    #20 btn_in[0] = 1'b1;
    #10 btn_in[0] = 1'b0;
    @(posedge clk);
    t_edge = longint'($time);
    #1 btn_in[0] = 1'b1;
    repeat (51) @(posedge clk);
    #1 check("bounce_level_at51", int'(btn_level[0]), 0);
    @(posedge clk);
    #1 check("bounce_level_at52", int'(btn_level[0]), 1);
    repeat (6) @(posedge clk);
    #1;
    check("bounce_events", ev_q.size(), 1);
    check("bounce_id", ev_id(0), 0);
    check("bounce_type", ev_typ(0), 0);
    check("bounce_hs_cycle", (ev_q.size() > 0) ? int'((ev_q[0].t - t_edge) / T_CLK) : -1, 54);

    // simultaneous presses, releases, then round-robin pointer ordering
    apply_reset();
    event_ready = 1'b1;
    btn_in[1] = 1'b1;
    btn_in[3] = 1'b1;
    repeat (80) @(negedge clk);
    check("rr_hs_gap", (ev_q.size() > 1) ? int'((ev_q[1].t - ev_q[0].t) / T_CLK) : -1, 2);
    btn_in[1] = 1'b0;
    btn_in[3] = 1'b0;
    repeat (80) @(negedge clk);
    btn_in[2] = 1'b1;
    repeat (80) @(negedge clk);
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b1;
    repeat (80) @(negedge clk);
    exp_ids = '{1, 3, 1, 3, 2, 3, 0};
    exp_typ = '{0, 0, 1, 1, 0, 0, 0};
    check("rr_events", ev_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("rr_id%0d", i), ev_id(i), exp_ids[i]);
      check($sformatf("rr_type%0d", i), ev_typ(i), exp_typ[i]);
    end

    // overflow with consumer stalled
    apply_reset();
    btn_in[0] = 1'b1;
    repeat (60) @(negedge clk);
    check("ovf_p1_valid", int'(event_valid), 1);
    check("ovf_p1_id", int'(event_id), 0);
    check("ovf_p1_flag", int'(overflow), 0);
    btn_in[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("ovf_rel_flag", int'(overflow), 0);
    check("ovf_rel_type", int'(event_type), 0);
    btn_in[0] = 1'b1;
    repeat (60) @(negedge clk);
    check("ovf_p2_flag", int'(overflow), 1);
    check("ovf_p2_valid", int'(event_valid), 1);
    check("ovf_p2_id", int'(event_id), 0);
    check("ovf_p2_type", int'(event_type), 0);
    event_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_drain_events", ev_q.size(), 2);
    check("ovf_drain_type0", ev_typ(0), 0);
    check("ovf_drain_type1", ev_typ(1), 1);
    check("ovf_sticky", int'(overflow), 1);

    // long hold on channel 0
    apply_reset();
    event_ready = 1'b1;
    btn_in[0] = 1'b1;
    repeat (300) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (80) @(negedge clk);
`ifdef LONG_PRESS_EN
    check("long_events", ev_q.size(), 3);
    check("long_type0", ev_typ(0), 0);
    check("long_type1", ev_typ(1), 2);
    check("long_type2", ev_typ(2), 1);
`else
    check("long_events", ev_q.size(), 2);
    check("long_type0", ev_typ(0), 0);
    check("long_type1", ev_typ(1), 1);
    check("long_never", int'(saw_long), 0);
`endif

    // reset mid-debounce, button held through reset
    apply_reset();
    btn_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    #5 rst_a_n = 1'b0;
    #1;
    check("rstchk_level", int'(btn_level), 0);
    check("rstchk_valid", int'(event_valid), 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (51) @(posedge clk);
    #1 check("rsthold_level_at51", int'(btn_level[1]), 0);
    @(posedge clk);
    #1 check("rsthold_level_at52", int'(btn_level[1]), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (event_valid) break;
    end
    check("rstev_valid_before", int'(event_valid), 1);
    check("rstev_id_before", int'(event_id), 1);
    #3 rst_a_n = 1'b0;
    #1;
    check("rstev_valid", int'(event_valid), 0);
    check("rstev_id", int'(event_id), 0);
    check("rstev_type", int'(event_type), 0);
    check("rstev_level", int'(btn_level), 0);
    btn_in = '0;
    @(negedge clk);
    rst_a_n = 1'b1;
    ev_q.delete();
    event_ready = 1'b1;
    repeat (120) @(negedge clk);
    check("rstev_no_stale", ev_q.size(), 0);
    check("rstev_idle", int'(event_valid), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
